// File: rtl/cart_bank_pkg.sv
// cart_bank_pkg: state/mode types, image bases and control window decode.
// XEGS support is compiled in only when CART_XEGS_EN is defined.
package cart_bank_pkg;

    localparam int FULL_AW = 22;
    typedef logic [FULL_AW-1:0] faddr_t;

    typedef enum logic [1:0] {
        ST_SDX  = 2'd0,
        ST_CART = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        M8K    = 3'd0,
        M16K   = 3'd1,
        OSS034 = 3'd2,
        OSS043 = 3'd3,
        XEGS   = 3'd4
    } mode_e;

    localparam faddr_t BASE_OSS043 = 22'h20000;
    localparam faddr_t BASE_OSS034 = 22'h24000;
    localparam faddr_t BASE_M16K   = 22'h28000;
    localparam faddr_t BASE_M8K    = 22'h2C000;
    localparam faddr_t BASE_XEGS   = 22'h40000;

    localparam int         WIN_LSB = 5;
    localparam logic [2:0] WIN_TAG = 3'b111;

    function automatic logic in_win(input logic [7:0] lo);
        return lo[7:WIN_LSB] == WIN_TAG;
    endfunction

    function automatic mode_e cfg_mode(input logic [2:0] cfg);
        mode_e m;
        case (cfg[1:0])
            2'b00:   m = M8K;
            2'b01:   m = M16K;
            2'b10:   m = OSS034;
            default: m = OSS043;
        endcase
        if (cfg[2]) begin
`ifdef CART_XEGS_EN
            m = XEGS;
`else
            m = M8K;
`endif
        end
        return m;
    endfunction

    function automatic logic is_oss(input mode_e m);
        return (m == OSS034) || (m == OSS043);
    endfunction

    function automatic logic rd4_on(input mode_e m);
        return (m == M16K) || (m == XEGS);
    endfunction

endpackage

// File: rtl/cart_bank_if.sv
// cart_bank_if: cartridge bus and ROM bus bundle around the bank controller.
// Carries the XEGS-independent signal set; CART_XEGS_EN changes nothing here.
interface cart_bank_if #(
    parameter int ROM_AW = 19
);
    logic [12:0]       cart_a;
    logic [7:0]        cart_d_i;
    logic [7:0]        cart_d_o;
    logic              cart_d_oe;
    logic              s4_n;
    logic              s5_n;
    logic              cctl_n;
    logic              r_w;
    logic [2:0]        cfg;
    logic [7:0]        rom_d_i;
    logic              rd4;
    logic              rd5;
    logic [ROM_AW-1:0] rom_a;
    logic              rom_ce_n;
    logic              rom_oe_n;
    logic              led_y;
    logic              led_r;

    modport master (
        output cart_a, cart_d_i, s4_n, s5_n, cctl_n, r_w, cfg, rom_d_i,
        input  cart_d_o, cart_d_oe, rd4, rd5, rom_a,
        input  rom_ce_n, rom_oe_n, led_y, led_r
    );

    modport slave (
        input  cart_a, cart_d_i, s4_n, s5_n, cctl_n, r_w, cfg, rom_d_i,
        output cart_d_o, cart_d_oe, rd4, rd5, rom_a,
        output rom_ce_n, rom_oe_n, led_y, led_r
    );

endinterface

// File: rtl/cart_rom_amux.sv
// cart_rom_amux: combinational ROM address map for every state and mode.
// The XEGS windows exist only when CART_XEGS_EN is defined.
module cart_rom_amux
    import cart_bank_pkg::*;
#(
    parameter int ROM_AW     = 19,
    parameter int SDX_BANK_W = 4
`ifdef CART_XEGS_EN
    ,
    parameter int XEGS_BANK_W = 4
`endif
) (
    input  state_e                 state_i,
    input  mode_e                  mode_i,
    input  logic                   s4_n_i,
    input  logic                   s5_n_i,
    input  logic [12:0]            a_i,
    input  logic [SDX_BANK_W-1:0]  sdx_bank_i,
    input  logic [1:0]             oss_bank_i,
`ifdef CART_XEGS_EN
    input  logic [XEGS_BANK_W-1:0] xegs_bank_i,
`endif
    output logic [ROM_AW-1:0]      rom_a_o
);

    faddr_t full;
    faddr_t a_x;
    faddr_t sdx_a;
    faddr_t oss_a;
`ifdef CART_XEGS_EN
    faddr_t xe4_a;
    faddr_t xe5_a;
`endif

    // candidate addresses for each image window
    always_comb begin
        a_x        = '0;
        a_x[12:0]  = a_i;
        sdx_a      = '0;
        sdx_a[SDX_BANK_W+12:0] = {sdx_bank_i, a_i};
        oss_a      = '0;
        oss_a[11:0]  = a_i[11:0];
        oss_a[13:12] = a_i[12] ? 2'b11 : oss_bank_i;
        oss_a = oss_a |
            ((mode_i == OSS043) ? BASE_OSS043 : BASE_OSS034);
`ifdef CART_XEGS_EN
        xe4_a = '0;
        xe4_a[XEGS_BANK_W+12:0] = {xegs_bank_i, a_i};
        xe4_a = xe4_a | BASE_XEGS;
        xe5_a = '0;
        xe5_a[XEGS_BANK_W+12:0] = {{XEGS_BANK_W{1'b1}}, a_i};
        xe5_a = xe5_a | BASE_XEGS;
`endif
    end

    // pick the window addressed by state, mode and selects
    always_comb begin
        full = '0;
        unique case (state_i)
            ST_SDX: begin
                if (!s5_n_i) full = sdx_a;
            end
            ST_CART: begin
                case (mode_i)
                    OSS034, OSS043: begin
                        if (!s5_n_i) full = oss_a;
                    end
                    M16K: begin
                        if (!s4_n_i)
                            full = BASE_M16K | a_x;
                        else if (!s5_n_i)
                            full = BASE_M16K | 22'h02000 | a_x;
                    end
                    M8K: begin
                        if (!s5_n_i) full = BASE_M8K | a_x;
                    end
`ifdef CART_XEGS_EN
                    XEGS: begin
                        if (!s4_n_i)
                            full = xe4_a;
                        else if (!s5_n_i)
                            full = xe5_a;
                    end
`endif
                    default: full = '0;
                endcase
            end
            default: full = '0;
        endcase
    end

    assign rom_a_o = full[ROM_AW-1:0];

    if (ROM_AW < FULL_AW) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^full[FULL_AW-1:ROM_AW];
    end

endmodule

// File: rtl/cart_bank_ctrl.sv
// cart_bank_ctrl: SDX / cartridge-image bank controller on the phi2 clock.
// Define CART_XEGS_EN to build the XEGS mode and its bank register.
module cart_bank_ctrl
    import cart_bank_pkg::*;
#(
    parameter int ROM_AW      = 19,
    parameter int SDX_BANK_W  = 4,
    parameter int XEGS_BANK_W = 4
) (
    input  logic              phi2,
    input  logic              reset_n,
    input  logic [12:0]       cart_a,
    input  logic [7:0]        cart_d_i,
    output logic [7:0]        cart_d_o,
    output logic              cart_d_oe,
    input  logic              s4_n,
    input  logic              s5_n,
    input  logic              cctl_n,
    input  logic              r_w,
    input  logic [2:0]        cfg,
    input  logic [7:0]        rom_d_i,
    output logic              rd4,
    output logic              rd5,
    output logic [ROM_AW-1:0] rom_a,
    output logic              rom_ce_n,
    output logic              rom_oe_n,
    output logic              led_y,
    output logic              led_r
);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [SDX_BANK_W-1:0] sdx_bank_q, sdx_bank_d, sdx_wr;
    logic [1:0]            oss_bank_q, oss_bank_d;
    logic                  rd4_q, rd4_d;
    logic                  rd5_q, rd5_d;
    logic                  ctl_wr;
    logic                  win;
    logic                  o43;
    logic                  sel4, sel5;
    logic                  unused_d;
`ifdef CART_XEGS_EN
    logic [XEGS_BANK_W-1:0] xegs_bank_q, xegs_bank_d;
`else
    localparam int unused_xw = XEGS_BANK_W;
`endif

    assign ctl_wr   = !cctl_n && !r_w;
    assign win      = in_win(cart_a[7:0]);
    assign o43      = (mode_q == OSS043);
    assign unused_d = ^cart_d_i;

    // SDX bank index is stored inverted; data bits extend wide banks
    assign sdx_wr[3:0] = ~{cart_a[4], cart_a[2:0]};
    if (SDX_BANK_W > 4) begin : g_sdx_hi
        assign sdx_wr[SDX_BANK_W-1:4] = ~cart_d_i[SDX_BANK_W-5:0];
    end

    // state and bank registers, reset wins over any write
    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            state_q    <= ST_SDX;
            mode_q     <= M8K;
            sdx_bank_q <= '1;
            oss_bank_q <= 2'b00;
            rd4_q      <= 1'b0;
            rd5_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sdx_bank_q <= sdx_bank_d;
            oss_bank_q <= oss_bank_d;
            rd4_q      <= rd4_d;
            rd5_q      <= rd5_d;
        end
    end

`ifdef CART_XEGS_EN
    // XEGS bank register
    always_ff @(posedge phi2) begin
        if (!reset_n) xegs_bank_q <= '0;
        else          xegs_bank_q <= xegs_bank_d;
    end
`endif

    // next state: decode control writes per state and mode
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sdx_bank_d = sdx_bank_q;
        oss_bank_d = oss_bank_q;
        rd4_d      = rd4_q;
        rd5_d      = rd5_q;
`ifdef CART_XEGS_EN
        xegs_bank_d = xegs_bank_q;
`endif
        if (ctl_wr) begin
            unique case (state_q)
                ST_SDX: begin
                    if (win) begin
                        case (cart_a[3:2])
                            2'b10: begin
                                state_d = ST_CART;
                                mode_d  = cfg_mode(cfg);
                                rd4_d   = rd4_on(cfg_mode(cfg));
                                rd5_d   = 1'b1;
                            end
                            2'b11: begin
                                state_d = ST_OFF;
                                rd4_d   = 1'b0;
                                rd5_d   = 1'b0;
                            end
                            default: begin
                                sdx_bank_d = sdx_wr;
                                rd4_d      = 1'b0;
                                rd5_d      = 1'b1;
                            end
                        endcase
                    end
                end
                ST_CART: begin
                    if (is_oss(mode_q)) begin
                        unique case (1'b1)
                            cart_a[3]: begin
                                state_d = ST_OFF;
                                rd5_d   = 1'b0;
                            end
                            (cart_a[3:0] == 4'b0000):
                                oss_bank_d = 2'b00;
                            (!cart_a[3] && cart_a[1:0] == 2'b11):
                                oss_bank_d = o43 ? 2'b10 : 2'b01;
                            (cart_a[3:0] == 4'b0100):
                                oss_bank_d = o43 ? 2'b01 : 2'b10;
                            default:
                                oss_bank_d = 2'b11;
                        endcase
                    end else if (win) begin
                        if (cart_a[3:2] == 2'b11) begin
                            state_d = ST_OFF;
                            rd4_d   = 1'b0;
                            rd5_d   = 1'b0;
                        end
                    end
`ifdef CART_XEGS_EN
                    else if (mode_q == XEGS) begin
                        xegs_bank_d = cart_d_i[XEGS_BANK_W-1:0];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // bus strobes, data drive and status LEDs
    always_comb begin
        sel4      = rd4_q & ~s4_n;
        sel5      = rd5_q & ~s5_n;
        rom_ce_n  = ~(sel4 | sel5);
        rom_oe_n  = ~((sel4 | sel5) & r_w);
        cart_d_oe = r_w & phi2 & ((sel4 & s5_n) | (sel5 & s4_n));
        led_y     = (state_q != ST_SDX);
        led_r     = !((state_q == ST_CART) && !is_oss(mode_q));
    end

    assign rd4      = rd4_q;
    assign rd5      = rd5_q;
    assign cart_d_o = rom_d_i;

    cart_rom_amux #(
        .ROM_AW      (ROM_AW),
        .SDX_BANK_W  (SDX_BANK_W)
`ifdef CART_XEGS_EN
        ,
        .XEGS_BANK_W (XEGS_BANK_W)
`endif
    ) u_amux (
        .state_i     (state_q),
        .mode_i      (mode_q),
        .s4_n_i      (s4_n),
        .s5_n_i      (s5_n),
        .a_i         (cart_a),
        .sdx_bank_i  (sdx_bank_q),
        .oss_bank_i  (oss_bank_q),
`ifdef CART_XEGS_EN
        .xegs_bank_i (xegs_bank_q),
`endif
        .rom_a_o     (rom_a)
    );

endmodule
